// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-I execute stage.
// This package holds the ALU operation enum, the ALUOp/funct encodings, the mult/div FSM states,
// and the helper that turns ALUOp plus funct into an ALU operation.
package mips_pkg;

    localparam int DATA_W      = 32;
    localparam int MULDIV_ITER = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    // ALU_ZERO covers every funct that has no ALU meaning, including mult/div themselves.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_HI, ALU_PASS_LO, ALU_ZERO
    } alu_op_e;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} muldiv_state_e;

    // ALU control: the fixed ALUOp codes win, otherwise the funct field picks the operation.
    function automatic alu_op_e decodeAluOp(input logic [1:0] aluOp, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_ZERO;
        case (aluOp)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_OR:  op = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: op = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: op = ALU_SUB;
                    FUNCT_AND:             op = ALU_AND;
                    FUNCT_OR:              op = ALU_OR;
                    FUNCT_XOR:             op = ALU_XOR;
                    FUNCT_NOR:             op = ALU_NOR;
                    FUNCT_SLT:             op = ALU_SLT;
                    FUNCT_SLTU:            op = ALU_SLTU;
                    FUNCT_SLL:             op = ALU_SLL;
                    FUNCT_SRL:             op = ALU_SRL;
                    FUNCT_SRA:             op = ALU_SRA;
                    FUNCT_MFHI:            op = ALU_PASS_HI;
                    FUNCT_MFLO:            op = ALU_PASS_LO;
                    default:               op = ALU_ZERO;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with the HI/LO registers.
// Multiply is shift-add on operand magnitudes and divide is restoring division on magnitudes;
// the sign is reapplied after the last iteration. Define EX_DIV_EN to build the divider,
// otherwise only mult/multu exist and the divide datapath is absent.
module mul_div_unit
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    muldiv_state_e state_q;
    logic [4:0]    count_q;
    logic [31:0]   opnd_q;
    logic [31:0]   accHi_q;
    logic [31:0]   accLo_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          negRes_q;

    logic          isSigned;
    logic          aNeg;
    logic          bNeg;
    logic [31:0]   magA;
    logic [31:0]   magB;
    logic [32:0]   mulSum;
    logic [63:0]   prod;
    logic [31:0]   stepHi;
    logic [31:0]   stepLo;
    logic [31:0]   finHi;
    logic [31:0]   finLo;

`ifdef EX_DIV_EN
    logic          isDiv_q;
    logic          negRem_q;
    logic          divZero_q;
    logic [32:0]   remShift;
    logic [33:0]   remDiff;
    logic          unusedDiffBit;

    assign unusedDiffBit = remDiff[32];
`else
    logic          unusedOpBit;

    assign unusedOpBit = op_i[1];
`endif

    // mult and div are the signed variants (op bit 0 clear); magnitudes feed the iterations.
    assign isSigned = ~op_i[0];
    assign aNeg     = isSigned & a_i[31];
    assign bNeg     = isSigned & b_i[31];
    assign magA     = aNeg ? -a_i : a_i;
    assign magB     = bNeg ? -b_i : b_i;

    assign busy_o = ~reset & (((state_q == MD_IDLE) & start_i) | (state_q == MD_BUSY));
    assign done_o = (state_q == MD_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // One iteration of the active operation, plus the sign-corrected result used on the last one.
    always_comb begin
        mulSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : 33'd0);
        stepHi = mulSum[32:1];
        stepLo = {mulSum[0], accLo_q[31:1]};
        prod   = {stepHi, stepLo};
        if (negRes_q) begin
            prod = -prod;
        end
        finHi = prod[63:32];
        finLo = prod[31:0];
`ifdef EX_DIV_EN
        remShift = {accHi_q, accLo_q[31]};
        remDiff  = {1'b0, remShift} - {2'b00, opnd_q};
        if (isDiv_q) begin
            stepHi = remDiff[33] ? remShift[31:0] : remDiff[31:0];
            stepLo = {accLo_q[30:0], ~remDiff[33]};
            finLo  = divZero_q ? 32'hFFFF_FFFF : (negRes_q ? -stepLo : stepLo);
            finHi  = negRem_q ? -stepHi : stepHi;
        end
`endif
    end

    // IDLE latches operands, BUSY runs the iterations and writes HI/LO, DONE lets the instruction retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            opnd_q    <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            negRes_q  <= 1'b0;
`ifdef EX_DIV_EN
            isDiv_q   <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_q  <= MD_BUSY;
                        count_q  <= '0;
                        accHi_q  <= '0;
                        negRes_q <= aNeg ^ bNeg;
`ifdef EX_DIV_EN
                        isDiv_q   <= op_i[1];
                        negRem_q  <= aNeg;
                        divZero_q <= (b_i == '0);
                        opnd_q    <= op_i[1] ? magB : magA;
                        accLo_q   <= op_i[1] ? magA : magB;
`else
                        opnd_q    <= magA;
                        accLo_q   <= magB;
`endif
                    end
                end
                MD_BUSY: begin
                    accHi_q <= stepHi;
                    accLo_q <= stepLo;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'(MULDIV_ITER - 1)) begin
                        hi_q    <= finHi;
                        lo_q    <= finLo;
                        state_q <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS-I execute stage: ALU, branch target adder, destination mux and pipeline stall.
// The multiply/divide unit lives in mul_div_unit; while it is working ex_stall holds the front
// of the pipeline. Define EX_DIV_EN to enable div/divu; without it they are no-ops.
module ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ctrl_aluOp_id_ex,
    input  logic              ctrl_aluSrc_id_ex,
    input  logic              ctrl_regDest_id_ex,
    input  logic [DATA_W-1:0] supposed_next_address_id_ex,
    input  logic [DATA_W-1:0] read_data_1_id_ex,
    input  logic [DATA_W-1:0] read_data_2_id_ex,
    input  logic [DATA_W-1:0] extended_branch_offset_id_ex,
    input  logic [DATA_W-1:0] next_instruction_20_16_id_ex,
    input  logic [DATA_W-1:0] next_instruction_15_11_id_ex,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic [DATA_W-1:0] branch_target,
    output logic [4:0]        write_reg,
    output logic              ex_stall,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] operandB;
    alu_op_e     aluCtrl;
    logic        mdStart;
    logic        mdBusy;
    logic        mdDone;
    logic [31:0] hiVal;
    logic [31:0] loVal;
    logic [31:0] aluOut;
    logic        unusedBits;

    assign funct    = extended_branch_offset_id_ex[5:0];
    assign shamt    = extended_branch_offset_id_ex[10:6];
    assign operandB = ctrl_aluSrc_id_ex ? extended_branch_offset_id_ex : read_data_2_id_ex;
    assign aluCtrl  = decodeAluOp(ctrl_aluOp_id_ex, funct);

    // Only the R-type mult/div functs launch the iterative unit; div/divu only when the divider exists.
    always_comb begin
        mdStart = 1'b0;
        if (ctrl_aluOp_id_ex == ALUOP_FUNCT) begin
            case (funct)
                FUNCT_MULT, FUNCT_MULTU: mdStart = 1'b1;
`ifdef EX_DIV_EN
                FUNCT_DIV, FUNCT_DIVU:   mdStart = 1'b1;
`endif
                default:                 mdStart = 1'b0;
            endcase
        end
    end

    mul_div_unit u_mulDiv (
        .clk     (clk),
        .reset   (reset),
        .start_i (mdStart),
        .op_i    (funct[1:0]),
        .a_i     (read_data_1_id_ex),
        .b_i     (read_data_2_id_ex),
        .busy_o  (mdBusy),
        .done_o  (mdDone),
        .hi_o    (hiVal),
        .lo_o    (loVal)
    );

    // The ALU proper; shifts act on rt by shamt, mfhi/mflo pass the HI/LO registers through.
    always_comb begin
        aluOut = '0;
        case (aluCtrl)
            ALU_ADD:     aluOut = read_data_1_id_ex + operandB;
            ALU_SUB:     aluOut = read_data_1_id_ex - operandB;
            ALU_AND:     aluOut = read_data_1_id_ex & operandB;
            ALU_OR:      aluOut = read_data_1_id_ex | operandB;
            ALU_XOR:     aluOut = read_data_1_id_ex ^ operandB;
            ALU_NOR:     aluOut = ~(read_data_1_id_ex | operandB);
            ALU_SLT:     aluOut = {31'b0, $signed(read_data_1_id_ex) < $signed(operandB)};
            ALU_SLTU:    aluOut = {31'b0, read_data_1_id_ex < operandB};
            ALU_SLL:     aluOut = read_data_2_id_ex << shamt;
            ALU_SRL:     aluOut = read_data_2_id_ex >> shamt;
            ALU_SRA:     aluOut = $signed(read_data_2_id_ex) >>> shamt;
            ALU_PASS_HI: aluOut = hiVal;
            ALU_PASS_LO: aluOut = loVal;
            default:     aluOut = '0;
        endcase
    end

    assign alu_result    = aluOut;
    assign alu_zero      = (aluOut == '0);
    assign branch_target = supposed_next_address_id_ex + {extended_branch_offset_id_ex[29:0], 2'b00};
    assign write_reg     = ctrl_regDest_id_ex ? next_instruction_15_11_id_ex[4:0]
                                              : next_instruction_20_16_id_ex[4:0];
    assign ex_stall      = mdBusy;
    assign hi_q          = hiVal;
    assign lo_q          = loVal;

    // Upper register-field bits and the done pulse have no consumer in this stage.
    assign unusedBits = ^{next_instruction_20_16_id_ex[31:5], next_instruction_15_11_id_ex[31:5], mdDone};

endmodule
